branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Fetch-side branch predictor: a direct-mapped branch target buffer with 2-bit saturating direction counters. It answers a combinational lookup for the fetch PC (predicted-taken flag and next PC) and is trained one update per cycle by the execute stage with resolved branch/jump outcomes. It also keeps a saturating mispredict counter for performance debug.

## Interface
Parameters:
- ENTRIES, 16, number of entries; power of two, at least 2; IDX_W = log2(ENTRIES)
- CNT_W, 16, width of the mispredict performance counter

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-high
- fetch_pc  input  32  PC being fetched (word aligned)
- predicted_taken  output  1  lookup hit and counter in a taken state
- predicted_pc  output  32  next fetch PC: stored target if predicted_taken, else fetch_pc + 4
- update_en  input  1  execute-stage training strobe for a resolved control-flow instruction
- update_pc  input  32  PC of the resolved instruction
- update_taken  input  1  actual direction (1 = taken)
- update_target  input  32  computed jump/branch target
- mispredict  input  1  execute redirected fetch this cycle; counted only when update_en = 1
- flush_all  input  1  invalidate every entry
- mispredict_count  output  CNT_W  saturating count of mispredicts

## Operation
- Index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]; pc[1:0] is ignored.
- Per entry: valid (1), tag, target (32), cnt (2). Counter states: SNT=00, WNT=01, WT=10, ST=11; taken when cnt[1] = 1.
- Lookup (combinational from registered state): hit = valid[idx] && tag match; predicted_taken = hit && cnt[1]; predicted_pc = predicted_taken ? target : fetch_pc + 4 (32-bit wrap).
- Update with update_en = 1:
  - Hit, taken: cnt saturating increment (ST stays ST); target <= update_target.
  - Hit, not taken: cnt saturating decrement (SNT stays SNT); target unchanged.
  - Miss, taken: allocate/replace: valid <= 1, tag <= update tag, target <= update_target, cnt <= WT.
  - Miss, not taken: no state change.
- flush_all: all valid <= 0 at the next edge; takes priority over a same-cycle update (that update is discarded). Targets, tags, counters need not be cleared.
- mispredict_count increments when update_en && mispredict; holds at all-ones. It is not cleared by flush_all.

## Timing
- Lookup latency 0 cycles (combinational); update visible to lookup on the cycle after the update edge.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents.
- Reset (asynchronous, any time, including mid-update): all valid = 0, all cnt = WNT, mispredict_count = 0. Outputs immediately reflect this: predicted_taken = 0, predicted_pc = fetch_pc + 4.
- At most one update per cycle; no backpressure, no handshake beyond update_en.
- update_en = 0: no state change except flush_all.

## Structure
- Shared package: counter state constants (SNT/WNT/WT/ST), BTB_ENTRIES default, index/tag width derivations.
- One sub-module: btb_sat_counter (combinational 2-bit next-state from current state and taken); state arrays and mispredict counter stay in the top module.

## Test plan
- Reset then lookup fetch_pc = 0x0000_0040 -> predicted_taken = 0, predicted_pc = 0x0000_0044.
- Update pc 0x40, taken, target 0x100 -> next cycle lookup 0x40 gives predicted_taken = 1, predicted_pc = 0x100 (cnt = WT); a second not-taken update -> cnt = WNT, predicted_pc = 0x44.
- Alias: train 0x40 taken to 0x100, then train 0x80 (same index, tag 2) taken to 0x200 -> lookup 0x40 misses (0x44), lookup 0x80 gives 0x200.
- Saturation: four taken updates then one not-taken -> still predicted taken (ST->WT); from SNT, not-taken update stays SNT; miss not-taken creates no entry.
- flush_all asserted with a same-cycle taken update to 0xC0 -> next cycle all lookups miss, including 0xC0; asynchronous rst pulse mid-cycle clears mispredict_count at once.
- Assert update_en && mispredict for 2^CNT_W + 3 cycles -> mispredict_count holds at all-ones; mispredict without update_en -> no increment.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: direction counter encodings
// and the index/tag geometry derived from the entry count.
package branch_target_buffer_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_state_e;

    localparam int BTB_ENTRIES = 16;
    localparam int PC_W        = 32;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // The two low PC bits are never part of the tag since fetch is word aligned.
    function automatic int tag_width(input int entries);
        return PC_W - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state logic for a 2-bit saturating branch direction counter.
module btb_sat_counter
    import branch_target_buffer_pkg::*;
(
    input  cnt_state_e state,
    input  logic       taken,
    output cnt_state_e next_state
);

    always_comb begin
        next_state = state;
        case (state)
            CNT_SNT: next_state = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: next_state = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  next_state = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  next_state = taken ? CNT_ST  : CNT_WT;
            default: next_state = CNT_WNT;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters, a
// combinational fetch lookup, one training update per cycle and a mispredict counter.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       fetch_pc,
    output logic              predicted_taken,
    output logic [31:0]       predicted_pc,
    input  logic              update_en,
    input  logic [31:0]       update_pc,
    input  logic              update_taken,
    input  logic [31:0]       update_target,
    input  logic              mispredict,
    input  logic              flush_all,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int TAG_W = tag_width(ENTRIES);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [31:0]        targets [ENTRIES];
    cnt_state_e         cnts    [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    cnt_state_e       cnt_next;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[31:IDX_W+2];
    assign upd_idx   = update_pc[IDX_W+1:2];
    assign upd_tag   = update_pc[31:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not visible yet.
    assign fetch_hit       = valid[fetch_idx] && (tags[fetch_idx] == fetch_tag);
    assign predicted_taken = fetch_hit && cnts[fetch_idx][1];
    assign predicted_pc    = predicted_taken ? targets[fetch_idx] : fetch_pc + 32'd4;

    assign upd_hit = valid[upd_idx] && (tags[upd_idx] == upd_tag);

    btb_sat_counter u_sat_counter (
        .state      (cnts[upd_idx]),
        .taken      (update_taken),
        .next_state (cnt_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnts[i] <= CNT_WNT;
            end
        end else if (flush_all) begin
            valid <= '0;
        end else if (update_en) begin
            if (upd_hit) begin
                cnts[upd_idx] <= cnt_next;
            end else if (update_taken) begin
                valid[upd_idx] <= 1'b1;
                cnts[upd_idx]  <= CNT_WT;
            end
        end
    end

    // Tag and target carry no reset; valid alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (update_en && !flush_all && update_taken) begin
            tags[upd_idx]    <= upd_tag;
            targets[upd_idx] <= update_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_count <= '0;
        end else if (update_en && mispredict && (mispredict_count != '1)) begin
            mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: lookups push their expected result
// when driven and are popped and compared once the combinational output settles.
module tb_branch_target_buffer;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      fetch_pc;
    logic             predicted_taken;
    logic [31:0]      predicted_pc;
    logic             update_en;
    logic [31:0]      update_pc;
    logic             update_taken;
    logic [31:0]      update_target;
    logic             mispredict;
    logic             flush_all;
    logic [CNT_W-1:0] mispredict_count;

    typedef struct {
        string       name;
        logic        taken;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    branch_target_buffer #(.ENTRIES(16), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .predicted_taken  (predicted_taken),
        .predicted_pc     (predicted_pc),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .mispredict       (mispredict),
        .flush_all        (flush_all),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic look(input logic [31:0] pc, input logic taken, input logic [31:0] npc, input string name);
        exp_t x;
        fetch_pc = pc;
        x.name = name; x.taken = taken; x.pc = npc;
        sb.push_back(x);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic misp);
        update_en = 1'b1; update_pc = pc; update_taken = taken; update_target = tgt; mispredict = misp;
        @(posedge clk); #1;
        update_en = 1'b0; mispredict = 1'b0;
        if (misp) exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_all = 1'b0; update_en = 1'b0; mispredict = 1'b0;
        update_pc = '0; update_taken = 1'b0; update_target = '0;
        look(32'h40, 1'b0, 32'h44, "reset_lookup");
        #2;
        e = sb.pop_front(); n_checks++;
        if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
            n_fail++;
            $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
        end
        n_checks++;
        if (mispredict_count !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL reset_count: got %0d, want 0", mispredict_count);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        look(32'h40, 1'b0, 32'h44, "post_reset_lookup");
        #1;
        e = sb.pop_front(); n_checks++;
        if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
            n_fail++;
            $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
        end
    endtask

    task automatic test_train();
        // Update and lookup of the same PC in one cycle: lookup sees the old (empty) entry.
        update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_target = 32'h100; mispredict = 1'b0;
        look(32'h40, 1'b0, 32'h44, "same_cycle_lookup");
        #1;
        e = sb.pop_front(); n_checks++;
        if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
            n_fail++;
            $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
        end
        @(posedge clk); #1;
        update_en = 1'b0;
        look(32'h40, 1'b1, 32'h100, "train_alloc_wt");
        #1;
        e = sb.pop_front(); n_checks++;
        if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
            n_fail++;
            $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
        end
        do_update(32'h40, 1'b0, 32'h999, 1'b1);
        look(32'h40, 1'b0, 32'h44, "train_wt_to_wnt");
        #1;
        e = sb.pop_front(); n_checks++;
        if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
            n_fail++;
            $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
        end
    endtask

    task automatic test_alias();
        logic [31:0] pcs  [3] = '{32'h40, 32'h40, 32'h80};
        logic        tk   [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] npcs [3] = '{32'h100, 32'h44, 32'h200};
        do_update(32'h40, 1'b1, 32'h100, 1'b0);
        look(pcs[0], tk[0], npcs[0], "alias_first_owner");
        #1;
        e = sb.pop_front(); n_checks++;
        if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
            n_fail++;
            $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
        end
        do_update(32'h80, 1'b1, 32'h200, 1'b1);
        for (int i = 1; i < 3; i++) begin
            look(pcs[i], tk[i], npcs[i], $sformatf("alias_lookup_%0h", pcs[i]));
            #1;
            e = sb.pop_front(); n_checks++;
            if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
                n_fail++;
                $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
            end
        end
    endtask

    task automatic test_saturation();
        // Each step: one update, then a lookup of 0x104 with the expected outcome.
        logic        st_tk   [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] st_tgt  [11] = '{32'h300, 32'h4F0, 32'h4F4, 32'h4F8, 32'h500, 32'h0, 32'h0, 32'h0, 32'h0, 32'h600, 32'h700};
        logic        exp_tk  [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_pc  [11] = '{32'h108, 32'h4F0, 32'h4F4, 32'h4F8, 32'h500, 32'h500, 32'h108, 32'h108, 32'h108, 32'h108, 32'h700};
        for (int i = 0; i < 11; i++) begin
            do_update(32'h104, st_tk[i], st_tgt[i], 1'b0);
            look(32'h104, exp_tk[i], exp_pc[i], $sformatf("sat_step_%0d", i));
            #1;
            e = sb.pop_front(); n_checks++;
            if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
                n_fail++;
                $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] pcs  [3] = '{32'hC0, 32'h80, 32'h104};
        logic [31:0] npcs [3] = '{32'hC4, 32'h84, 32'h108};
        flush_all = 1'b1;
        do_update(32'hC0, 1'b1, 32'h600, 1'b0);
        flush_all = 1'b0;
        for (int i = 0; i < 3; i++) begin
            look(pcs[i], 1'b0, npcs[i], $sformatf("flush_lookup_%0h", pcs[i]));
            #1;
            e = sb.pop_front(); n_checks++;
            if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
                n_fail++;
                $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
            end
        end
        n_checks++;
        if (mispredict_count !== CNT_W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL flush_keeps_count: got %0d, want %0d", mispredict_count, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_update(32'h80, 1'b1, 32'h200, 1'b1);
        look(32'h80, 1'b1, 32'h200, "pre_async_reset");
        #1;
        e = sb.pop_front(); n_checks++;
        if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
            n_fail++;
            $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
        end
        n_checks++;
        if (mispredict_count !== CNT_W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL pre_async_count: got %0d, want %0d", mispredict_count, exp_cnt);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        exp_cnt = 0;
        look(32'h80, 1'b0, 32'h84, "async_reset_lookup");
        #1;
        e = sb.pop_front(); n_checks++;
        if (predicted_taken !== e.taken || predicted_pc !== e.pc) begin
            n_fail++;
            $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h", e.name, predicted_taken, predicted_pc, e.taken, e.pc);
        end
        n_checks++;
        if (mispredict_count !== CNT_W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL async_reset_count: got %0d, want %0d", mispredict_count, exp_cnt);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mispredict_sat();
        update_en = 1'b0; mispredict = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mispredict_count !== CNT_W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL misp_without_update: got %0d, want %0d", mispredict_count, exp_cnt);
        end
        update_en = 1'b1; update_pc = 32'h1000; update_taken = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            @(posedge clk); #1;
            exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1;
            n_checks++;
            if (mispredict_count !== CNT_W'(exp_cnt)) begin
                n_fail++;
                $display("FAIL misp_count_cycle_%0d: got %0d, want %0d", i, mispredict_count, exp_cnt);
            end
        end
        update_en = 1'b0; mispredict = 1'b0;
        n_checks++;
        if (mispredict_count !== {CNT_W{1'b1}}) begin
            n_fail++;
            $display("FAIL misp_count_saturated: got %0d, want %0d", mispredict_count, CNT_MAX);
        end
    endtask

    initial begin
        fetch_pc = 32'h0;
        test_reset();
        test_train();
        test_alias();
        test_saturation();
        test_flush();
        test_async_reset();
        test_mispredict_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
